// File: rtl/gin_multicast_net.sv
// Global Input Network: one-entry buffer fed by the GLB, multicast to every PE whose
// scanned-in (YID, XID) pair matches the buffered tags, all-or-nothing per cycle.
`ifndef NUMS_PE_ROW
`define NUMS_PE_ROW 4
`endif
`ifndef NUMS_PE_COL
`define NUMS_PE_COL 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif
`ifndef XID_BITS
`define XID_BITS 4
`endif
`ifndef YID_BITS
`define YID_BITS 4
`endif

module gin_multicast_net #(
  parameter int NUMS_PE_ROW = `NUMS_PE_ROW,
  parameter int NUMS_PE_COL = `NUMS_PE_COL,
  parameter int DATA_BITS   = `DATA_BITS,
  parameter int XID_BITS    = `XID_BITS,
  parameter int YID_BITS    = `YID_BITS
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       GIN_valid,
  output logic                                       GIN_ready,
  input  logic [DATA_BITS-1:0]                       GIN_data,
  input  logic [XID_BITS-1:0]                        tag_X,
  input  logic [YID_BITS-1:0]                        tag_Y,
  input  logic                                       set_XID,
  input  logic [XID_BITS-1:0]                        XID_scan_in,
  input  logic                                       set_YID,
  input  logic [YID_BITS-1:0]                        YID_scan_in,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         PE_valid,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         PE_ready,
  output logic [DATA_BITS*NUMS_PE_ROW*NUMS_PE_COL-1:0] PE_data,
  output logic                                       GIN_drop
);

  localparam int NPE = NUMS_PE_ROW * NUMS_PE_COL;

  logic [NPE-1:0][XID_BITS-1:0]         xid_q, xid_d;
  logic [NUMS_PE_ROW-1:0][YID_BITS-1:0] yid_q, yid_d;

  logic                 buf_valid_q, buf_valid_d;
  logic [DATA_BITS-1:0] buf_data_q, buf_data_d;
  logic [XID_BITS-1:0]  buf_tx_q, buf_tx_d;
  logic [YID_BITS-1:0]  buf_ty_q, buf_ty_d;

  logic [NPE-1:0] match_s;
  logic           all_rdy_s;
  logic           deliver_s;
  logic           drop_s;
  logic           accept_s;

  // Scan chains: entry 0 takes the input, every other entry takes its predecessor.
  assign xid_d[0] = set_XID ? XID_scan_in : xid_q[0];
  assign yid_d[0] = set_YID ? YID_scan_in : yid_q[0];
  for (genvar g = 1; g < NPE; g++) begin : g_xid_shift
    assign xid_d[g] = set_XID ? xid_q[g-1] : xid_q[g];
  end
  for (genvar g = 1; g < NUMS_PE_ROW; g++) begin : g_yid_shift
    assign yid_d[g] = set_YID ? yid_q[g-1] : yid_q[g];
  end

  for (genvar g = 0; g < NPE; g++) begin : g_match
    assign match_s[g] = buf_valid_q && (yid_q[g / NUMS_PE_COL] == buf_ty_q)
                        && (xid_q[g] == buf_tx_q);
  end

  assign all_rdy_s = &(~match_s | PE_ready);
  assign deliver_s = buf_valid_q && (|match_s) && all_rdy_s;
  assign drop_s    = buf_valid_q && !(|match_s);
  assign GIN_ready = rst && !set_XID && !set_YID && (!buf_valid_q || deliver_s || drop_s);
  assign accept_s  = GIN_valid && GIN_ready;

  assign PE_valid = match_s & {NPE{all_rdy_s}};
  assign PE_data  = {NPE{buf_data_q}};
  assign GIN_drop = drop_s;

  // A same-cycle accept overwrites the word that is leaving, giving full-rate pass-through.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    buf_tx_d    = buf_tx_q;
    buf_ty_d    = buf_ty_q;
    if (accept_s) begin
      buf_valid_d = 1'b1;
      buf_data_d  = GIN_data;
      buf_tx_d    = tag_X;
      buf_ty_d    = tag_Y;
    end else if (deliver_s || drop_s) begin
      buf_valid_d = 1'b0;
    end else begin
      buf_valid_d = buf_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xid_q       <= '0;
      yid_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      buf_tx_q    <= '0;
      buf_ty_q    <= '0;
    end else begin
      xid_q       <= xid_d;
      yid_q       <= yid_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      buf_tx_q    <= buf_tx_d;
      buf_ty_q    <= buf_ty_d;
    end
  end

endmodule

// File: tb/tb_gin_multicast_net.sv
// Randomized bench for gin_multicast_net against a cycle-level reference model.
module tb_gin_multicast_net;
  localparam int R   = 4;
  localparam int C   = 8;
  localparam int NPE = R * C;
  localparam int DW  = 32;
  localparam int XB  = 4;
  localparam int YB  = 4;
  localparam int CW  = DW * NPE;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              GIN_valid = 1'b0;
  logic              GIN_ready;
  logic [DW-1:0]     GIN_data = '0;
  logic [XB-1:0]     tag_X = '0;
  logic [YB-1:0]     tag_Y = '0;
  logic              set_XID = 1'b0;
  logic [XB-1:0]     XID_scan_in = '0;
  logic              set_YID = 1'b0;
  logic [YB-1:0]     YID_scan_in = '0;
  logic [NPE-1:0]    PE_valid;
  logic [NPE-1:0]    PE_ready = '1;
  logic [CW-1:0]     PE_data;
  logic              GIN_drop;

  gin_multicast_net #(.NUMS_PE_ROW(R), .NUMS_PE_COL(C), .DATA_BITS(DW),
                      .XID_BITS(XB), .YID_BITS(YB)) dut (
    .clk(clk), .rst(rst), .GIN_valid(GIN_valid), .GIN_ready(GIN_ready),
    .GIN_data(GIN_data), .tag_X(tag_X), .tag_Y(tag_Y),
    .set_XID(set_XID), .XID_scan_in(XID_scan_in),
    .set_YID(set_YID), .YID_scan_in(YID_scan_in),
    .PE_valid(PE_valid), .PE_ready(PE_ready), .PE_data(PE_data), .GIN_drop(GIN_drop));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: ID tables and the single pending word.
  int            xid_m [NPE];
  int            yid_m [R];
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_tx, m_ty;

  logic [NPE-1:0] last_pv;
  logic           last_drop;
  logic           last_ready;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (xid_m[i]) xid_m[i] = 0;
    foreach (yid_m[i]) yid_m[i] = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_tx    = 0;
    m_ty    = 0;
  endtask

  function automatic logic [NPE-1:0] targets();
    logic [NPE-1:0] t = '0;
    for (int i = 0; i < NPE; i++)
      t[i] = m_valid && (yid_m[i / C] == m_ty) && (xid_m[i] == m_tx);
    return t;
  endfunction

  // One clock cycle: drive, check the combinational response, then advance the model.
  task automatic step(input bit v, input logic [DW-1:0] d, input int tx, input int ty,
                      input bit sx, input int xin, input bit sy, input int yin,
                      input logic [NPE-1:0] rdy);
    logic [NPE-1:0] tgt;
    bit all_rdy, deliver, drop, exp_ready;
    @(negedge clk);
    GIN_valid = v; GIN_data = d; tag_X = XB'(tx); tag_Y = YB'(ty);
    set_XID = sx; XID_scan_in = XB'(xin); set_YID = sy; YID_scan_in = YB'(yin);
    PE_ready = rdy;
    #1;
    tgt       = targets();
    all_rdy   = 1'b1;
    for (int i = 0; i < NPE; i++) if (tgt[i] && !rdy[i]) all_rdy = 1'b0;
    deliver   = (tgt != '0) && all_rdy;
    drop      = m_valid && (tgt == '0);
    exp_ready = !sx && !sy && (!m_valid || deliver || drop);
    check("pe_valid", CW'(PE_valid), CW'(deliver ? tgt : '0));
    check("gin_ready", CW'(GIN_ready), CW'(exp_ready));
    check("gin_drop", CW'(GIN_drop), CW'(drop));
    check("pe_data", PE_data, {NPE{m_data}});
    last_pv = PE_valid; last_drop = GIN_drop; last_ready = GIN_ready;
    @(posedge clk);
    if (v && exp_ready) begin
      m_valid = 1'b1; m_data = d; m_tx = tx; m_ty = ty;
    end else if (deliver || drop) begin
      m_valid = 1'b0;
    end
    if (sx) begin
      for (int i = NPE - 1; i > 0; i--) xid_m[i] = xid_m[i-1];
      xid_m[0] = xin;
    end
    if (sy) begin
      for (int i = R - 1; i > 0; i--) yid_m[i] = yid_m[i-1];
      yid_m[0] = yin;
    end
  endtask

  task automatic idle(input logic [NPE-1:0] rdy);
    step(1'b0, '0, 0, 0, 1'b0, 0, 1'b0, 0, rdy);
  endtask

  initial begin
    logic [NPE-1:0] all1;
    logic [NPE-1:0] one_hot;
    all1 = '1;
    model_reset();
    #2;
    check("reset_ready", CW'(GIN_ready), CW'(1'b0));
    check("reset_pe_valid", CW'(PE_valid), CW'(0));
    check("reset_pe_data", PE_data, CW'(0));
    check("reset_drop", CW'(GIN_drop), CW'(1'b0));
    #20;
    rst = 1'b1;

    // Program XID[i] = i % C and YID[r] = r; the first value shifted in ends up deepest.
    for (int i = NPE - 1; i >= 0; i--)
      step(1'b0, '0, 0, 0, 1'b1, i % C, (i < R), i, all1);

    // Point-to-point to row 2, column 3.
    step(1'b1, 32'hDEADBEEF, 3, 2, 1'b0, 0, 1'b0, 0, all1);
    idle(all1);
    one_hot = '0;
    one_hot[2*C+3] = 1'b1;
    check("p2p_target", CW'(last_pv), CW'(one_hot));
    check("p2p_ready", CW'(last_ready), CW'(1'b1));

    // No row carries YID 15: the word is dropped one cycle later.
    step(1'b1, 32'h12345678, 0, 15, 1'b0, 0, 1'b0, 0, all1);
    idle(all1);
    check("nomatch_drop", CW'(last_drop), CW'(1'b1));
    check("nomatch_pv", CW'(last_pv), CW'(0));

    // Scan gating: request held while set_XID is high, then taken.
    step(1'b1, 32'hA5A5A5A5, 1, 1, 1'b1, 1, 1'b0, 0, all1);
    check("scan_gate_ready", CW'(last_ready), CW'(1'b0));
    step(1'b1, 32'hA5A5A5A5, 1, 1, 1'b0, 0, 1'b0, 0, all1);
    idle(all1);

    // Random traffic with sparse rescans and mostly-ready PEs.
    for (int n = 0; n < 400; n++) begin
      bit sx, sy;
      sx = ($urandom_range(0, 19) == 0);
      sy = ($urandom_range(0, 39) == 0);
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9), $urandom_range(0, 4),
           sx, $urandom_range(0, 7), sy, $urandom_range(0, 3),
           ~(NPE'($urandom) & NPE'($urandom) & NPE'($urandom)));
    end
    idle(all1);
    idle(all1);

    // Async reset with a blocked word in the buffer.
    step(1'b1, 32'h0BADF00D, m_tx, m_ty, 1'b0, 0, 1'b0, 0, all1);
    for (int i = 0; i < NPE; i++) step(1'b0, '0, 0, 0, 1'b1, i % 3, 1'b1, i % 2, all1);
    step(1'b1, 32'hCAFE0001, 0, 0, 1'b0, 0, 1'b0, 0, '0);
    idle('0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("arst_pe_valid", CW'(PE_valid), CW'(0));
    check("arst_ready", CW'(GIN_ready), CW'(1'b0));
    check("arst_pe_data", PE_data, CW'(0));
    @(negedge clk);
    #2 rst = 1'b1;
    step(1'b1, 32'h77777777, 0, 0, 1'b0, 0, 1'b0, 0, all1);
    idle(all1);
    check("post_reset_bcast", CW'(last_pv), CW'(all1));
    idle(all1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
